// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct values, and the select/ALU encodings driven on the control outputs.
package multicycle_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU control (single-cycle encoding)
    localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;
    localparam logic [ALUC_W-1:0] ALU_NONE = 3'b000;

    // aluop between FSM and ALU decoder; NONE drives alucontrol to zero
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_NONE  = 2'b11;

    // ALU B source
    localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // True for the R-type functs the datapath implements
    function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                               funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop (and funct for R-type) to the ALU control code.
//   funct      in  R-type function field
//   aluop      in  operation class from the FSM
//   alucontrol out ALU operation
module mc_aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] aluop,
    output logic [ALUC_W-1:0]  alucontrol
);

    always_comb begin
        alucontrol = ALU_NONE;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with a shared, possibly stalling memory.
// Outputs are Moore decodes of the state, except irwrite/pcen in FETCH
// (gated by mem_ready) and pcen in BRANCH (gated by zero).
//   clk, reset       clock, async active-high reset
//   op, funct        instruction fields from the IR
//   zero             ALU zero flag (BRANCH)
//   mem_ready        memory access completes this cycle
//   iord..illegal    datapath control strobes and selects
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [SEL_W-1:0]   alusrcb,
    output logic [SEL_W-1:0]   pcsrc,
    output logic               pcen,
    output logic [ALUC_W-1:0]  alucontrol,
    output logic               illegal
);

    state_t              r_state;
    state_t              w_next;
    logic [ALUOP_W-1:0]  w_aluop;

    // State register; reset forces FETCH without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    mc_aludec u_aludec (
        .funct      (funct),
        .aluop      (w_aluop),
        .alucontrol (alucontrol)
    );

    // Next-state and output decode
    always_comb begin
        w_next   = S_FETCH;
        w_aluop  = ALUOP_NONE;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REGB;
        pcsrc    = PCSRC_ALU;
        pcen     = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                w_aluop = ALUOP_ADD;
                // reset may be asserted while parked here; keep the IR and PC quiet
                irwrite = mem_ready & ~reset;
                pcen    = mem_ready & ~reset;
                w_next  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM_SH2;
                w_aluop = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_aluop = ALUOP_ADD;
                if (op == OP_LW)      w_next = S_MEMREAD;
                else if (op == OP_SW) w_next = S_MEMWRITE;
                else                  w_next = S_FETCH;
            end
            S_MEMREAD: begin
                iord   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWRITE: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
                illegal = ~funct_legal(funct);
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcen    = zero;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_aluop = ALUOP_ADD;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver walks each instruction
// through its expected phase sequence and queues the expected control word
// per cycle; a monitor pops and compares one word every cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, illegal;
    logic [2:0] alucontrol;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECUTE, P_ALUWB, P_BRANCH, P_ADDIEXEC, P_ADDIWB, P_JUMP} phase_t;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [15:0] got;
    assign got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, pcen, alucontrol, illegal};

    // Expected control word for one cycle of a phase, from the behavioural tables
    function automatic logic [15:0] exp_word(input phase_t p, input logic mr,
                                             input logic z, input logic [5:0] o,
                                             input logic [5:0] f);
        logic e_iord = 0, e_mw = 0, e_irw = 0, e_rd = 0, e_m2r = 0, e_rw = 0, e_a = 0;
        logic [1:0] e_b = 0, e_pc = 0;
        logic e_pcen = 0, e_ill = 0;
        logic [2:0] e_alu = 0;
        case (p)
            P_FETCH:    begin e_b = 2'b01; e_alu = 3'b010; e_irw = mr; e_pcen = mr; end
            P_DECODE: begin
                e_b = 2'b11; e_alu = 3'b010;
                e_ill = !(o == 6'h23 || o == 6'h2b || o == 6'h00 ||
                          o == 6'h04 || o == 6'h08 || o == 6'h02);
            end
            P_MEMADR:   begin e_a = 1; e_b = 2'b10; e_alu = 3'b010; end
            P_MEMREAD:  e_iord = 1;
            P_MEMWRITE: begin e_iord = 1; e_mw = 1; end
            P_MEMWB:    begin e_m2r = 1; e_rw = 1; end
            P_EXECUTE: begin
                e_a = 1; e_b = 2'b00;
                if      (f == 6'd32) e_alu = 3'b010;  // add
                else if (f == 6'd34) e_alu = 3'b110;  // sub
                else if (f == 6'd36) e_alu = 3'b000;  // and
                else if (f == 6'd37) e_alu = 3'b001;  // or
                else if (f == 6'd42) e_alu = 3'b111;  // slt
                else begin e_alu = 3'b010; e_ill = 1; end
            end
            P_ALUWB:    begin e_rd = 1; e_rw = 1; end
            P_BRANCH:   begin e_a = 1; e_alu = 3'b110; e_pc = 2'b01; e_pcen = z; end
            P_ADDIEXEC: begin e_a = 1; e_b = 2'b10; e_alu = 3'b010; end
            P_ADDIWB:   e_rw = 1;
            P_JUMP:     begin e_pc = 2'b10; e_pcen = 1; end
            default: ;
        endcase
        return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_b, e_pc, e_pcen, e_alu, e_ill};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s got=%h exp=%h t=%0t", name, act, req, $time);
        else n_pass++;
    endtask

    // Monitor: one expected word per cycle while the scoreboard holds entries
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, got, e.exp);
        end
    end

    // Drive one instruction; entered and left at posedge+1 with the DUT in FETCH.
    // fst/mst: stall cycles in FETCH and in the data memory phase; zsel 0/1 fixed, 2 random.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                             input int fst, input int mst, input int zsel);
        phase_t ph[$];
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (iop)
            6'h23: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
            6'h2b: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWRITE); end
            6'h00: begin ph.push_back(P_EXECUTE); ph.push_back(P_ALUWB); end
            6'h04: ph.push_back(P_BRANCH);
            6'h08: begin ph.push_back(P_ADDIEXEC); ph.push_back(P_ADDIWB); end
            6'h02: ph.push_back(P_JUMP);
            default: ;
        endcase
        foreach (ph[k]) begin
            bit is_mem = (ph[k] == P_FETCH || ph[k] == P_MEMREAD || ph[k] == P_MEMWRITE);
            int stall = (ph[k] == P_FETCH) ? fst : (is_mem ? mst : 0);
            for (int c = 0; c <= stall; c++) begin
                exp_t e;
                op = iop;
                funct = ifn;
                mem_ready = is_mem ? (c == stall) : 1'($urandom_range(0, 1));
                zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
                e.tag = ph[k].name();
                e.exp = exp_word(ph[k], mem_ready, zero, iop, ifn);
                sb.push_back(e);
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [5:0] legal_ops[6]  = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
    logic [5:0] legal_fns[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset takes effect before any clock edge; strobes forced low
        mem_ready = 1'b1;
        #3 reset = 1'b1;
        #1 chk("reset_async", got, exp_word(P_FETCH, 1'b0, 1'b0, 6'h00, 6'h00));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", got, exp_word(P_FETCH, 1'b0, 1'b0, 6'h00, 6'h00));
        mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed: R-sub with fetch stall, lw with stall, beq both ways, illegal op,
        // sw with stall, addi, j, R-type with bad funct
        run_instr(6'h00, 6'h22, 3, 0, 2);
        run_instr(6'h23, 6'h00, 0, 2, 2);
        run_instr(6'h04, 6'h00, 0, 0, 1);
        run_instr(6'h04, 6'h00, 0, 0, 0);
        run_instr(6'h3f, 6'h00, 0, 0, 2);
        run_instr(6'h2b, 6'h00, 0, 1, 2);
        run_instr(6'h08, 6'h11, 0, 0, 2);
        run_instr(6'h02, 6'h00, 0, 0, 2);
        run_instr(6'h00, 6'h3f, 0, 0, 2);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            logic [5:0] rop, rfn;
            int s = $urandom_range(0, 7);
            rop = (s < 6) ? legal_ops[s] : 6'($urandom);
            s = $urandom_range(0, 5);
            rfn = (s < 5) ? legal_fns[s] : 6'($urandom);
            run_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), 2);
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_total++;
        if (sb.size() != 0) $display("FAIL drain left=%0d exp=0", sb.size());
        else n_pass++;

        // Reset in the middle of a stalled sw MEMWRITE
        @(posedge clk);
        #1;
        op = 6'h2b; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #1 chk("sw_memwrite", got, exp_word(P_MEMWRITE, 1'b0, 1'b0, 6'h2b, 6'h00));
        #1;
        mem_ready = 1'b1;
        reset = 1'b1;
        #1 chk("sw_reset_midcycle", got, exp_word(P_FETCH, 1'b0, 1'b0, 6'h2b, 6'h00));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_fetch", got, exp_word(P_FETCH, 1'b1, 1'b0, 6'h2b, 6'h00));
        @(posedge clk);
        #1 chk("post_reset_decode", got, exp_word(P_DECODE, 1'b1, 1'b0, 6'h2b, 6'h00));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
